// File: rtl/conv_scan_ctrl_pkg.sv
// Shared constants and state type for the convolution/dense scan sequencer.
package conv_scan_ctrl_pkg;

   localparam int unsigned IDX_W = 10;
   localparam int unsigned MAT_W = 5;
   localparam int unsigned LAT_W = 3;

   localparam logic [1:0] PROV_INT   = 2'b00;
   localparam logic [1:0] PROV_RIGHT = 2'b10;
   localparam logic [1:0] PROV_LEFT  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_FIRE,
      ST_OUT,
      ST_DONE
   } scan_state_t;

endpackage

// File: rtl/conv_scan_pos.sv
// Pixel/step position tracker: index i, column counter with wrap at the
// feature-map side, last-index detect and the left/right edge flag.
module conv_scan_pos
   import conv_scan_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             advance,
   input  logic             active,
   input  logic             dense_en,
   input  logic [MAT_W-1:0] matrix,
   input  logic [IDX_W-1:0] n_in,
   output logic [IDX_W-1:0] i,
   output logic             last,
   output logic [1:0]       prov
);

   logic [MAT_W-1:0] col;
   logic [IDX_W-1:0] n_q;
   logic             at_right;

   assign at_right = (col == matrix - MAT_W'(1));
   assign last     = (i == n_q - IDX_W'(1));

   // Load the scan length on start, step index and column on each accepted result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i   <= '0;
         col <= '0;
         n_q <= '0;
      end else if (clear) begin
         i   <= '0;
         col <= '0;
         n_q <= n_in;
      end else if (advance) begin
         i   <= i + IDX_W'(1);
         col <= at_right ? '0 : col + MAT_W'(1);
      end
   end

   // Edge flag; forced interior when idle so every output is 0 out of reset.
   always_comb begin
      prov = PROV_INT;
      if (active && !dense_en) begin
         if (col == '0)
            prov = PROV_LEFT;
         else if (at_right)
            prov = PROV_RIGHT;
      end
   end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Sequencer for the 3x3 convolution / dense MAC datapath: walks the pixel or
// step index, waits out the window read latency, fires the MAC and hands each
// result index to writeback with a valid/ready handshake.
module conv_scan_ctrl
   import conv_scan_ctrl_pkg::*;
#(
   parameter int SIZE   = 23,
   parameter int RD_LAT = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dense_mode,
   input  logic [MAT_W-1:0] matrix_in,
   input  logic [IDX_W-1:0] dense_len,
   output logic [IDX_W-1:0] i,
   output logic [1:0]       prov,
   output logic [MAT_W-1:0] matrix,
   output logic [IDX_W-1:0] matrix2,
   output logic             conv_en,
   output logic             dense_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             busy,
   output logic             done,
   output logic             err
);

   if (SIZE < 1 || RD_LAT < 0 || RD_LAT > 7) begin : g_param_check
      $error("conv_scan_ctrl: SIZE must be >= 1 and RD_LAT within 0..7");
   end

   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
   localparam scan_state_t      STEP0    = (RD_LAT > 0) ? ST_FETCH : ST_FIRE;

   scan_state_t      state, state_next;
   logic [LAT_W-1:0] lat_cnt;
   logic [MAT_W-1:0] matrix_q;
   logic [IDX_W-1:0] matrix2_q;
   logic             dense_q;
   logic             err_q;
   logic             reject, accept, handshake, last;
   logic [IDX_W-1:0] sq, n_sel;

   assign sq        = IDX_W'(matrix_in) * IDX_W'(matrix_in);
   assign n_sel     = dense_mode ? dense_len : sq;
   assign reject    = dense_mode ? (dense_len == '0) : (matrix_in < MAT_W'(2));
   assign accept    = (state == ST_IDLE) && start && !abort && !reject;
   assign handshake = (state == ST_OUT) && out_ready && !abort;

   conv_scan_pos u_pos (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept),
      .advance  (handshake && !last),
      .active   (busy),
      .dense_en (dense_q),
      .matrix   (matrix_q),
      .n_in     (n_sel),
      .i        (i),
      .last     (last),
      .prov     (prov)
   );

   // Next-state and Moore strobes; abort overrides every transition.
   always_comb begin
      state_next = state;
      conv_en    = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      unique case (state)
         ST_IDLE:  if (accept) state_next = STEP0;
         ST_FETCH: if (lat_cnt == LAT_LAST) state_next = ST_FIRE;
         ST_FIRE: begin
            conv_en    = 1'b1;
            state_next = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = last ? ST_DONE : STEP0;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (abort) state_next = ST_IDLE;
   end

   // State, read-latency counter, latched scan configuration and reject strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         lat_cnt   <= '0;
         matrix_q  <= '0;
         matrix2_q <= '0;
         dense_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state   <= state_next;
         lat_cnt <= (state == ST_FETCH && state_next == ST_FETCH) ? lat_cnt + LAT_W'(1) : '0;
         err_q   <= (state == ST_IDLE) && start && !abort && reject;
         if (accept) begin
            matrix_q  <= matrix_in;
            matrix2_q <= sq;
            dense_q   <= dense_mode;
         end else if (state_next == ST_IDLE) begin
            dense_q   <= 1'b0;
         end
      end
   end

   assign matrix   = matrix_q;
   assign matrix2  = matrix2_q;
   assign dense_en = dense_q;
   assign err      = err_q;
   assign busy     = (state != ST_IDLE);
   assign out_idx  = i;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Self-checking bench for conv_scan_ctrl. A timeline model built from the scan
// timing rules gives the expected outputs for every cycle after a start edge;
// a tracker process drives start/out_ready/abort from it and compares.
module tb_conv_scan_ctrl;

   localparam int MAXC = 128;

   logic clk = 1'b0;
   logic rst_main = 1'b0;
   logic rst_trk = 1'b1;
   logic rst_n;
   logic tr_start = 1'b0;
   logic mn_start = 1'b0;
   logic sel = 1'b0;
   logic start_a, start_b;
   logic abort = 1'b0;
   logic out_ready = 1'b1;
   logic dense_mode = 1'b0;
   logic [4:0] matrix_in = '0;
   logic [9:0] dense_len = '0;

   logic [9:0] i_a, i_b, m2_a, m2_b, idx_a, idx_b;
   logic [4:0] m_a, m_b;
   logic [1:0] prov_a, prov_b;
   logic conv_a, conv_b, den_a, den_b, val_a, val_b;
   logic busy_a, busy_b, done_a, done_b, err_a, err_b;

   logic [9:0] s_i, s_m2, s_idx;
   logic [4:0] s_m;
   logic [1:0] s_prov;
   logic s_conv, s_den, s_val, s_busy, s_done, s_err;

   assign rst_n   = rst_main & rst_trk;
   assign start_a = (tr_start & ~sel) | mn_start;
   assign start_b = tr_start & sel;

   assign s_i    = sel ? i_b    : i_a;
   assign s_m2   = sel ? m2_b   : m2_a;
   assign s_idx  = sel ? idx_b  : idx_a;
   assign s_m    = sel ? m_b    : m_a;
   assign s_prov = sel ? prov_b : prov_a;
   assign s_conv = sel ? conv_b : conv_a;
   assign s_den  = sel ? den_b  : den_a;
   assign s_val  = sel ? val_b  : val_a;
   assign s_busy = sel ? busy_b : busy_a;
   assign s_done = sel ? done_b : done_a;
   assign s_err  = sel ? err_b  : err_a;

   conv_scan_ctrl #(.SIZE(23), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
      .dense_mode(dense_mode), .matrix_in(matrix_in), .dense_len(dense_len),
      .i(i_a), .prov(prov_a), .matrix(m_a), .matrix2(m2_a), .conv_en(conv_a),
      .dense_en(den_a), .out_valid(val_a), .out_ready(out_ready), .out_idx(idx_a),
      .busy(busy_a), .done(done_a), .err(err_a)
   );

   conv_scan_ctrl #(.SIZE(23), .RD_LAT(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
      .dense_mode(dense_mode), .matrix_in(matrix_in), .dense_len(dense_len),
      .i(i_b), .prov(prov_b), .matrix(m_b), .matrix2(m2_b), .conv_en(conv_b),
      .dense_en(den_b), .out_valid(val_b), .out_ready(out_ready), .out_idx(idx_b),
      .busy(busy_b), .done(done_b), .err(err_b)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int c, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, act, exp);
      end
   endtask

   // Expected timeline, indexed by cycles after the start edge.
   int e_conv[MAXC], e_valid[MAXC], e_i[MAXC], e_prov[MAXC], e_done[MAXC];
   int e_busy[MAXC], e_den[MAXC], e_pos[MAXC], e_ready[MAXC], e_abort[MAXC];
   int e_side, e_sq, tend, last_c, poke_c;
   int cut_mode;
   logic track = 1'b0;
   logic fin = 1'b0;
   int cyc = 0;

   task automatic build(input int lat, input int dn, input int side, input int len,
                        input int st_k, input int st_n, input int mode, input int cutc);
      int n, t, s, col, pv;
      for (int c = 0; c < MAXC; c++) begin
         e_conv[c] = 0; e_valid[c] = 0; e_i[c] = 0; e_prov[c] = 0; e_done[c] = 0;
         e_busy[c] = 0; e_den[c] = 0; e_pos[c] = 0; e_ready[c] = 1; e_abort[c] = 0;
      end
      n = (dn != 0) ? len : side * side;
      t = 1;
      for (int k = 0; k < n; k++) begin
         col = k % side;
         pv  = (dn != 0) ? 0 : (col == 0) ? 3 : (col == side - 1) ? 2 : 0;
         for (int f = 0; f <= lat; f++) begin
            e_busy[t] = 1; e_den[t] = dn; e_pos[t] = 1; e_i[t] = k; e_prov[t] = pv;
            e_conv[t] = (f == lat) ? 1 : 0;
            t++;
         end
         s = (k == st_k) ? st_n : 0;
         for (int r = 0; r <= s; r++) begin
            e_busy[t] = 1; e_den[t] = dn; e_pos[t] = 1; e_i[t] = k; e_prov[t] = pv;
            e_valid[t] = 1; e_ready[t] = (r == s) ? 1 : 0;
            t++;
         end
      end
      e_busy[t] = 1; e_den[t] = dn; e_done[t] = 1;
      tend = t;
      e_side = side;
      e_sq = side * side;
      cut_mode = mode;
      if (mode == 1) begin
         e_abort[cutc] = 1;
         for (int c = cutc + 1; c < MAXC; c++) begin
            e_conv[c] = 0; e_valid[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_den[c] = 0; e_pos[c] = 0;
         end
         last_c = cutc + 1;
      end else if (mode == 2) begin
         last_c = cutc;
      end else begin
         last_c = t + 1;
      end
   endtask

   // Drive start/out_ready/abort from the timeline and compare every cycle.
   always @(negedge clk) begin
      if (!track) begin
         cyc = 0; fin = 1'b0; tr_start = 1'b0; abort = 1'b0; out_ready = 1'b1; rst_trk = 1'b1;
      end else if (cyc == 0) begin
         tr_start = 1'b1;
         cyc = 1;
      end else begin
         tr_start = (cyc == poke_c);
         if (cyc <= last_c) begin
            chk("conv_en", cyc, s_conv, e_conv[cyc]);
            chk("out_valid", cyc, s_val, e_valid[cyc]);
            chk("done", cyc, s_done, e_done[cyc]);
            chk("busy", cyc, s_busy, e_busy[cyc]);
            chk("dense_en", cyc, s_den, e_den[cyc]);
            chk("err", cyc, s_err, 0);
            if (e_pos[cyc] != 0) begin
               chk("i", cyc, s_i, e_i[cyc]);
               chk("prov", cyc, s_prov, e_prov[cyc]);
            end
            if (e_valid[cyc] != 0) chk("out_idx", cyc, s_idx, e_i[cyc]);
            if (e_busy[cyc] != 0) begin
               chk("matrix", cyc, s_m, e_side);
               chk("matrix2", cyc, s_m2, e_sq);
            end
            out_ready = e_ready[cyc][0];
            abort = e_abort[cyc][0];
            if (cut_mode == 2 && cyc == last_c) begin
               rst_trk = 1'b0;
               #1;
               chk("rst_conv_en", cyc, s_conv, 0);
               chk("rst_busy", cyc, s_busy, 0);
               chk("rst_out_valid", cyc, s_val, 0);
               chk("rst_i", cyc, s_i, 0);
               chk("rst_prov", cyc, s_prov, 0);
               chk("rst_matrix2", cyc, s_m2, 0);
               chk("rst_dense_en", cyc, s_den, 0);
            end
            if (cyc == last_c) fin = 1'b1;
         end else begin
            abort = 1'b0;
            out_ready = 1'b1;
         end
         cyc++;
      end
   end

   task automatic run_scan(input int s, input int dn, input int side, input int len,
                           input int st_k, input int st_n, input int mode, input int cutc,
                           input int pk);
      bit ok;
      build((s != 0) ? 0 : 1, dn, side, len, st_k, st_n, mode, cutc);
      sel = s[0];
      dense_mode = dn[0];
      matrix_in = 5'(side);
      dense_len = 10'(len);
      poke_c = pk;
      @(posedge clk);
      track = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         if (fin) begin
            ok = 1'b1;
            break;
         end
      end
      chk("scan_finished", 0, int'(ok), 1);
      track = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int nconv;
      poke_c = -1;
      repeat (3) @(negedge clk);
      chk("reset_busy_a", 0, busy_a, 0);
      chk("reset_busy_b", 0, busy_b, 0);
      chk("reset_conv_en", 0, conv_a, 0);
      chk("reset_i", 0, i_a, 0);
      chk("reset_prov", 0, prov_a, 0);
      chk("reset_matrix2", 0, m2_a, 0);
      chk("reset_out_valid", 0, val_a, 0);
      chk("reset_done", 0, done_a, 0);
      chk("reset_err", 0, err_a, 0);
      rst_main = 1'b1;
      repeat (2) @(negedge clk);

      // Conv 4x4, RD_LAT=1, writeback always ready.
      build(1, 0, 4, 0, -1, 0, 0, 0);
      nconv = 0;
      for (int c = 0; c < MAXC; c++) nconv += e_conv[c];
      chk("model_done_cycle", 0, tend, 49);
      chk("model_conv_count", 0, nconv, 16);
      chk("model_prov_k0", 0, e_prov[2], 3);
      chk("model_prov_k3", 0, e_prov[11], 2);
      chk("model_prov_k5", 0, e_prov[17], 0);
      run_scan(0, 0, 4, 0, -1, 0, 0, 0, -1);
      chk("final_matrix2", 0, m2_a, 16);
      chk("final_i", 0, i_a, 15);

      // Same scan with writeback stalled 5 cycles at i=6.
      build(1, 0, 4, 0, 6, 5, 0, 0);
      chk("model_stall_done_cycle", 0, tend, 54);
      run_scan(0, 0, 4, 0, 6, 5, 0, 0, -1);

      // Dense, 5 steps, RD_LAT=0 instance.
      build(0, 1, 3, 5, -1, 0, 0, 0);
      chk("model_dense_done_cycle", 0, tend, 11);
      run_scan(1, 1, 3, 5, -1, 0, 0, 0, -1);
      chk("dense_en_cleared", 0, den_b, 0);
      sel = 1'b0;

      // Rejected starts: conv 1x1, then dense with zero length.
      for (int t = 0; t < 2; t++) begin
         dense_mode = t[0];
         matrix_in = 5'd1;
         dense_len = '0;
         @(negedge clk);
         mn_start = 1'b1;
         @(negedge clk);
         mn_start = 1'b0;
         chk("reject_err_pulse", t, err_a, 1);
         chk("reject_busy", t, busy_a, 0);
         chk("reject_conv_en", t, conv_a, 0);
         @(negedge clk);
         chk("reject_err_clear", t, err_a, 0);
         chk("reject_busy_after", t, busy_a, 0);
      end

      // Abort in OUT at i=7 (cycle 24), then a fresh 2x2 scan from i=0.
      run_scan(0, 0, 4, 0, -1, 0, 1, 24, -1);
      run_scan(0, 0, 2, 0, -1, 0, 0, 0, -1);

      // Async reset during FIRE at i=3 (cycle 11), then a clean full scan.
      run_scan(0, 0, 4, 0, -1, 0, 2, 11, -1);
      run_scan(0, 0, 4, 0, -1, 0, 0, 0, -1);

      // Extra start pulse mid-scan must not disturb the 3x3 sequence.
      run_scan(0, 0, 3, 0, -1, 0, 0, 0, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_scan_ctrl.md
Name: conv_scan_ctrl

Overview:
- Sequencer for the 3x3 convolution/dense MAC datapath.
- Walks pixel index i over one feature map (or dense group count) and drives i, prov, matrix, matrix2, conv_en and dense_en.
- Waits for the window buffer read latency before each conv_en pulse.
- Presents each result index with a valid/ready handshake to the writeback stage.

Parameters:
- SIZE, 23, datapath word width; fixes the result latency assumption only, no ports depend on it.
- RD_LAT, 1, cycles from a new i to window words w1..w19 being valid (0..7).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a scan when idle.
- abort  in  1  synchronous; returns to IDLE from any state.
- dense_mode  in  1  1 = dense scan, 0 = conv scan; sampled at start.
- matrix_in  in  5  feature-map side length; sampled at start.
- dense_len  in  10  dense step count; sampled at start.
- i  out  10  current pixel/step index.
- prov  out  2  edge flag: 2'b11 = left column (col 0), 2'b10 = right column (col matrix-1), 2'b00 = interior or dense.
- matrix  out  5  latched side length.
- matrix2  out  10  latched matrix*matrix.
- conv_en  out  1  one-cycle fire strobe to the MAC.
- dense_en  out  1  latched dense_mode, held for the whole scan.
- out_valid  out  1  result for out_idx is present on Y1.
- out_ready  in  1  writeback accepts the result.
- out_idx  out  10  index of the presented result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last accepted result.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: all outputs 0, state IDLE, col counter 0, latency counter 0.
- Start acceptance (IDLE only; start in any other state is ignored):
  - Reject when conv with matrix_in<2, or dense with dense_len==0: pulse err next cycle, stay IDLE.
  - Accept otherwise: latch matrix and dense_en, compute matrix2 = matrix_in*matrix_in (max 961, fits 10b), N = dense ? dense_len : matrix2.
  - Set i=0, col=0; go to FETCH if RD_LAT>0, else FIRE.
- FETCH: count RD_LAT cycles with i stable, then go to FIRE.
- FIRE: conv_en=1 for exactly one cycle; next state OUT.
- OUT:
  - Y1 is valid the cycle after FIRE. Assert out_valid with out_idx=i.
  - Hold out_valid, out_idx, i and prov until out_ready.
  - conv_en stays 0 while stalled, so Y1 is not disturbed.
- On the OUT handshake:
  - If i==N-1: go to DONE.
  - Otherwise: i++, col wraps to 0 when col==matrix-1 else col++; go to FETCH or FIRE.
- DONE: pulse done for one cycle, then IDLE. i, matrix and matrix2 hold their last values; dense_en clears.
- prov is combinational from registered state:
  - dense_en: 00.
  - conv, col==0: 11.
  - conv, col==matrix-1: 10.
  - conv, otherwise: 00.
  - matrix>=2 guarantees the left and right edges never coincide.
- Per-element latency with out_ready=1: RD_LAT+2 cycles. Scan total = N*(RD_LAT+2)+1 cycles from the start edge to the done pulse.
- abort: next state IDLE, conv_en/out_valid drop immediately, no done pulse. abort wins over a simultaneous out_ready.
- Async reset mid-scan: immediately all outputs 0 and state IDLE. No partial result is signalled.
- out_ready while out_valid=0: ignored.

Decomposition:
- Shared package constants:
  - PROV_INT=2'b00, PROV_RIGHT=2'b10, PROV_LEFT=2'b11.
  - State encoding IDLE/FETCH/FIRE/OUT/DONE.
  - IDX_W=10, MAT_W=5.
- One natural sub-module: conv_scan_pos. It holds the i/col counters with wrap-at-matrix and last-index compare, and outputs prov. The FSM stays in the top.

Test Plan:
- Conv matrix_in=4, RD_LAT=1, out_ready=1 → 16 results.
  - prov per row: 11,00,00,10.
  - conv_en every 3rd cycle.
  - done 49 cycles after start; matrix2=16.
- Same with out_ready low for 5 cycles at i=6 → out_valid, out_idx=6, i and prov held; no conv_en during the stall; done 5 cycles later.
- dense_mode=1, dense_len=5, RD_LAT=0 → dense_en=1 throughout, prov=00, out_idx 0..4, done at cycle 11, then dense_en=0.
- matrix_in=1 conv start, then dense_len=0 dense start → err pulse each time, busy stays 0, no conv_en.
- abort asserted in OUT at i=7 with out_ready=1 → IDLE next cycle, no done. A new start then restarts at i=0.
- rst_n low during FIRE at i=3 → conv_en and all outputs 0 asynchronously. After release, start runs a clean full scan.
- Start pulse while busy → ignored, scan result sequence unchanged.
